game_flow_ctrl: RTL and testbench

Parametrised game-flow and timebase controller for the road game top level. It owns the game state machine (idle, run, crash, over), the lives count, a BCD survival score and a difficulty level. It generates the single-cycle update, fast and drop strobes for the road/sprite engine. Strobes are suppressed outside RUN, and the update strobe speeds up with level.

---
 rtl/game_flow_if.sv | 33 +++
 rtl/game_flow_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_if.sv
// Game-flow controller signal bundle: player/renderer inputs and the
// timebase strobes, status and score returned to the top level.
// Strobe semantics: upsig, upsig_fast and drop are single-cycle pulses with
// no back-pressure; a consumer must act on the cycle a strobe is high.
interface game_flow_if #(
    parameter int LIVES        = 3,
    parameter int MAX_LEVEL    = 3,
    parameter int SCORE_DIGITS = 2
);
    logic                            start;
    logic                            colision;
    logic                            upsig;
    logic                            upsig_fast;
    logic                            drop;
    logic                            flash;
    logic [1:0]                      state;
    logic [$clog2(LIVES+1)-1:0]      lives;
    logic [$clog2(MAX_LEVEL+1)-1:0]  level;
    logic [4*SCORE_DIGITS-1:0]       score;
    logic                            game_over;

    // Host side: drives the button and collision flag, observes the rest.
    modport master (
        output start, colision,
        input  upsig, upsig_fast, drop, flash, state, lives, level, score, game_over
    );

    // Controller side.
    modport slave (
        input  start, colision,
        output upsig, upsig_fast, drop, flash, state, lives, level, score, game_over
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game-flow and timebase controller: IDLE/RUN/CRASH/OVER state machine,
// lives, BCD survival score, difficulty level and the road-engine strobes.
// The registered state is exported on bus.state for observation.
module game_flow_ctrl #(
    parameter int SEC_CYCLES   = 50000000,
    parameter int UPD_PERIOD   = 131072,
    parameter int FAST_PERIOD  = 524288,
    parameter int DROP_PERIOD  = 46837494,
    parameter int CRASH_CYCLES = 100000000,
    parameter int FLASH_CYCLES = 6250000,
    parameter int LIVES        = 3,
    parameter int LEVEL_SECS   = 10,
    parameter int MAX_LEVEL    = 3,
    parameter int SCORE_DIGITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    game_flow_if.slave bus
);

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int SEC_W   = cnt_w(SEC_CYCLES);
    localparam int UPD_W   = cnt_w(UPD_PERIOD);
    localparam int FAST_W  = cnt_w(FAST_PERIOD);
    localparam int DROP_W  = cnt_w(DROP_PERIOD);
    localparam int CRASH_W = cnt_w(CRASH_CYCLES);
    localparam int FLASH_W = cnt_w(FLASH_CYCLES);
    localparam int LVLC_W  = cnt_w(LEVEL_SECS);
    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);
    localparam int SCORE_W = 4 * SCORE_DIGITS;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_DIGITS{4'h9}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CRASH = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t               state_r;
    logic                 start_q;
    logic [SEC_W-1:0]     sec_cnt;
    logic [UPD_W-1:0]     upd_cnt;
    logic [FAST_W-1:0]    fast_cnt;
    logic [DROP_W-1:0]    drop_cnt;
    logic [CRASH_W-1:0]   crash_cnt;
    logic [FLASH_W-1:0]   flash_cnt;
    logic [LVLC_W-1:0]    lvl_cnt;
    logic [LIVES_W-1:0]   lives_r;
    logic [LEVEL_W-1:0]   level_r;
    logic [SCORE_W-1:0]   score_r;
    logic                 flash_r;
    logic                 upsig_r;
    logic                 fast_r;
    logic                 drop_r;
    logic                 start_re;
    logic [UPD_W-1:0]     upd_lim;

    // BCD +1 with per-digit carry; callers guard against the all-9s value.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign start_re = bus.start & ~start_q;
    // The update period halves per level; >= lets a level-up mid-count fire at once.
    assign upd_lim  = UPD_W'((UPD_PERIOD >> level_r) - 1);

    // Game state machine with all counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= S_IDLE;
            start_q   <= 1'b0;
            sec_cnt   <= '0;
            upd_cnt   <= '0;
            fast_cnt  <= '0;
            drop_cnt  <= '0;
            crash_cnt <= '0;
            flash_cnt <= '0;
            lvl_cnt   <= '0;
            lives_r   <= LIVES_W'(LIVES);
            level_r   <= '0;
            score_r   <= '0;
            flash_r   <= 1'b0;
            upsig_r   <= 1'b0;
            fast_r    <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            start_q <= bus.start;
            upsig_r <= 1'b0;
            fast_r  <= 1'b0;
            drop_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    lives_r <= LIVES_W'(LIVES);
                    level_r <= '0;
                    score_r <= '0;
                    lvl_cnt <= '0;
                    flash_r <= 1'b0;
                    if (start_re) begin
                        state_r  <= S_RUN;
                        sec_cnt  <= '0;
                        upd_cnt  <= '0;
                        fast_cnt <= '0;
                        drop_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (bus.colision) begin
                        // Crash beats any terminal count this cycle; dividers freeze.
                        state_r   <= S_CRASH;
                        lives_r   <= lives_r - LIVES_W'(1);
                        crash_cnt <= '0;
                        flash_cnt <= '0;
                        flash_r   <= 1'b1;
                    end else begin
                        if (sec_cnt == SEC_W'(SEC_CYCLES - 1)) begin
                            sec_cnt <= '0;
                            if (score_r != SCORE_MAX) begin
                                score_r <= bcd_inc(score_r);
                                if (lvl_cnt == LVLC_W'(LEVEL_SECS - 1)) begin
                                    lvl_cnt <= '0;
                                    if (level_r != LEVEL_W'(MAX_LEVEL))
                                        level_r <= level_r + LEVEL_W'(1);
                                end else begin
                                    lvl_cnt <= lvl_cnt + LVLC_W'(1);
                                end
                            end
                        end else begin
                            sec_cnt <= sec_cnt + SEC_W'(1);
                        end
                        if (upd_cnt >= upd_lim) begin
                            upd_cnt <= '0;
                            upsig_r <= 1'b1;
                        end else begin
                            upd_cnt <= upd_cnt + UPD_W'(1);
                        end
                        if (fast_cnt == FAST_W'(FAST_PERIOD - 1)) begin
                            fast_cnt <= '0;
                            fast_r   <= 1'b1;
                        end else begin
                            fast_cnt <= fast_cnt + FAST_W'(1);
                        end
                        if (drop_cnt == DROP_W'(DROP_PERIOD - 1)) begin
                            drop_cnt <= '0;
                            drop_r   <= 1'b1;
                        end else begin
                            drop_cnt <= drop_cnt + DROP_W'(1);
                        end
                    end
                end
                S_CRASH: begin
                    if (crash_cnt == CRASH_W'(CRASH_CYCLES - 1)) begin
                        state_r  <= (lives_r == '0) ? S_OVER : S_RUN;
                        flash_r  <= 1'b0;
                        upd_cnt  <= '0;
                        fast_cnt <= '0;
                        drop_cnt <= '0;
                    end else begin
                        crash_cnt <= crash_cnt + CRASH_W'(1);
                        if (flash_cnt == FLASH_W'(FLASH_CYCLES - 1)) begin
                            flash_cnt <= '0;
                            flash_r   <= ~flash_r;
                        end else begin
                            flash_cnt <= flash_cnt + FLASH_W'(1);
                        end
                    end
                end
                default: begin
                    // OVER: hold everything until a fresh start edge.
                    flash_r <= 1'b0;
                    if (start_re) begin
                        state_r <= S_IDLE;
                        lives_r <= LIVES_W'(LIVES);
                        level_r <= '0;
                        score_r <= '0;
                        lvl_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.upsig      = upsig_r;
    assign bus.upsig_fast = fast_r;
    assign bus.drop       = drop_r;
    assign bus.flash      = flash_r;
    assign bus.state      = state_r;
    assign bus.lives      = lives_r;
    assign bus.level      = level_r;
    assign bus.score      = score_r;
    assign bus.game_over  = (state_r == S_OVER);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: reset/idle, run timing and levels,
// score saturation, crash/flash/return, game over/restart, async reset.
module tb_game_flow_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    game_flow_if #(.LIVES(2), .MAX_LEVEL(2), .SCORE_DIGITS(2)) bus ();
    game_flow_if #(.LIVES(2), .MAX_LEVEL(2), .SCORE_DIGITS(2)) sbus ();

    game_flow_ctrl #(
        .SEC_CYCLES(10), .UPD_PERIOD(8), .FAST_PERIOD(4), .DROP_PERIOD(6),
        .CRASH_CYCLES(20), .FLASH_CYCLES(5), .LIVES(2), .LEVEL_SECS(3),
        .MAX_LEVEL(2), .SCORE_DIGITS(2)
    ) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    game_flow_ctrl #(
        .SEC_CYCLES(1), .UPD_PERIOD(8), .FAST_PERIOD(4), .DROP_PERIOD(6),
        .CRASH_CYCLES(20), .FLASH_CYCLES(5), .LIVES(2), .LEVEL_SECS(3),
        .MAX_LEVEL(2), .SCORE_DIGITS(2)
    ) dut_sat (.clk(clk), .reset(reset), .bus(sbus.slave));

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [63:0] upd_seen, fast_seen, drop_seen;
        logic [63:0] exp_upd, exp_fast, exp_drop;
        int          strobes;
        int          upd_list[$];
        checks = 0;
        errors = 0;
        upd_list = '{8, 16, 24, 31, 35, 39, 43, 47, 51, 55, 59};

        // 1. Reset and idle
        reset = 1'b1;
        bus.start = 1'b0;  bus.colision = 1'b0;
        sbus.start = 1'b0; sbus.colision = 1'b0;
        #1;
        check("rst_state", bus.state, 2'd0);
        check("rst_lives", bus.lives, 2'd2);
        check("rst_score", bus.score, 8'h00);
        check("rst_flash", bus.flash, 1'b0);
        step(); step();
        reset = 1'b0;
        strobes = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            strobes += int'(bus.upsig) + int'(bus.upsig_fast) + int'(bus.drop);
        end
        check("idle_strobes", strobes, 0);
        check("idle_state", bus.state, 2'd0);
        check("idle_score", bus.score, 8'h00);
        check("idle_lives", bus.lives, 2'd2);

        // 2. Start and run 60 cycles
        bus.start = 1'b1;
        step();
        check("run_entry", bus.state, 2'd1);
        bus.start = 1'b0;
        upd_seen = '0; fast_seen = '0; drop_seen = '0;
        exp_upd = '0; exp_fast = '0; exp_drop = '0;
        foreach (upd_list[i]) exp_upd[upd_list[i]] = 1'b1;
        for (int k = 4; k <= 60; k += 4) exp_fast[k] = 1'b1;
        for (int k = 6; k <= 60; k += 6) exp_drop[k] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 40) bus.start = 1'b1;   // start edge in RUN is ignored
            if (k == 41) bus.start = 1'b0;
            step();
            upd_seen[k]  = bus.upsig;
            fast_seen[k] = bus.upsig_fast;
            drop_seen[k] = bus.drop;
            if (k == 29) check("lvl_before_30", bus.level, 2'd0);
            if (k == 30) begin
                check("lvl_at_30", bus.level, 2'd1);
                check("score_at_30", bus.score, 8'h03);
            end
        end
        check("upd_pattern", upd_seen[31:0], exp_upd[31:0]);
        check("upd_pattern_hi", upd_seen[63:32], exp_upd[63:32]);
        check("fast_pattern", fast_seen[31:0], exp_fast[31:0]);
        check("fast_pattern_hi", fast_seen[63:32], exp_fast[63:32]);
        check("drop_pattern", drop_seen[31:0], exp_drop[31:0]);
        check("drop_pattern_hi", drop_seen[63:32], exp_drop[63:32]);
        check("score_60", bus.score, 8'h06);
        check("level_60", bus.level, 2'd2);
        check("run_state_60", bus.state, 2'd1);

        // 4. Collision on an upd terminal-count cycle (edge 61)
        bus.colision = 1'b1;
        step();
        check("crash_no_upsig", bus.upsig, 1'b0);
        check("crash_state", bus.state, 2'd2);
        check("crash_lives", bus.lives, 2'd1);
        check("crash_flash_on", bus.flash, 1'b1);
        strobes = 0;
        for (int j = 1; j <= 20; j++) begin
            if (j == 3) bus.colision = 1'b0;   // held colision ignored in CRASH
            step();
            strobes += int'(bus.upsig) + int'(bus.upsig_fast) + int'(bus.drop);
            if (j == 2)  check("crash_lives_held", bus.lives, 2'd1);
            if (j == 4)  check("flash_j4", bus.flash, 1'b1);
            if (j == 5)  check("flash_j5", bus.flash, 1'b0);
            if (j == 10) check("flash_j10", bus.flash, 1'b1);
            if (j == 15) check("flash_j15", bus.flash, 1'b0);
            if (j == 19) check("crash_j19", bus.state, 2'd2);
            if (j == 20) begin
                check("return_state", bus.state, 2'd1);
                check("return_flash", bus.flash, 1'b0);
            end
        end
        check("crash_strobes", strobes, 0);
        step();
        check("ret_upsig_j21", bus.upsig, 1'b0);
        step();
        check("ret_upsig_j22", bus.upsig, 1'b1);
        check("ret_score", bus.score, 8'h06);
        check("ret_level", bus.level, 2'd2);

        // 5. Second crash, game over, restart
        bus.colision = 1'b1;
        step();
        bus.colision = 1'b0;
        check("crash2_state", bus.state, 2'd2);
        check("crash2_lives", bus.lives, 2'd0);
        for (int j = 1; j <= 19; j++) step();
        check("crash2_j19", bus.state, 2'd2);
        step();
        check("over_state", bus.state, 2'd3);
        check("over_flag", bus.game_over, 1'b1);
        check("over_flash", bus.flash, 1'b0);
        strobes = 0;
        for (int j = 0; j < 5; j++) begin
            step();
            strobes += int'(bus.upsig) + int'(bus.upsig_fast) + int'(bus.drop);
        end
        check("over_hold", bus.state, 2'd3);
        check("over_strobes", strobes, 0);
        bus.start = 1'b1;
        step();
        check("restart_idle", bus.state, 2'd0);
        check("restart_lives", bus.lives, 2'd2);
        check("restart_score", bus.score, 8'h00);
        check("restart_level", bus.level, 2'd0);
        check("restart_go", bus.game_over, 1'b0);
        step(); step(); step();
        check("held_start_idle", bus.state, 2'd0);
        bus.start = 1'b0;
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("second_start_run", bus.state, 2'd1);

        // 6. Asynchronous reset mid-CRASH
        bus.colision = 1'b1;
        step();
        bus.colision = 1'b0;
        check("pre_reset_crash", bus.state, 2'd2);
        step(); step(); step();
        #2;
        reset = 1'b1;
        #1;
        check("async_state", bus.state, 2'd0);
        check("async_flash", bus.flash, 1'b0);
        check("async_lives", bus.lives, 2'd2);
        step();
        reset = 1'b0;

        // 3. Score saturation with a 1-cycle second
        sbus.start = 1'b1;
        step();
        sbus.start = 1'b0;
        check("sat_run", sbus.state, 2'd1);
        for (int k = 1; k <= 120; k++) begin
            step();
            if (k == 50) check("sat_score_50", sbus.score, 8'h50);
            if (k == 99) check("sat_score_99", sbus.score, 8'h99);
        end
        check("sat_score_hold", sbus.score, 8'h99);
        check("sat_level_hold", sbus.level, 2'd2);
        check("sat_state", sbus.state, 2'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
